// File: rtl/graduation_list_nway_pkg.sv
// Shared types and constants for the N-way graduation list.
// Also holds the field layout of the opaque writeback word.
package graduation_list_nway_pkg;

  localparam int GL_NWAY_ENTRIES   = 32;
  localparam int GL_NWAY_IDX_W     = $clog2(GL_NWAY_ENTRIES);
  localparam int GL_NWAY_WB_DATA_W = 136;

  // Head/tail pointer: entry index plus one wrap bit.
  typedef logic [GL_NWAY_IDX_W:0] gl_nway_ptr_t;

  // Exception fields inside the writeback word.
  localparam int GL_WB_EXC_VALID_OFF  = 0;
  localparam int GL_WB_EXC_CAUSE_OFF  = 1;
  localparam int GL_WB_EXC_CAUSE_W    = 8;
  localparam int GL_WB_EXC_ORIGIN_OFF = 9;
  localparam int GL_WB_EXC_ORIGIN_W   = 64;
  localparam int GL_WB_FLAGS_OFF      = 73;
  localparam int GL_WB_FLAGS_W        = 63;

  function automatic logic [GL_NWAY_WB_DATA_W-1:0] gl_nway_exc_word(
    input logic [GL_WB_EXC_CAUSE_W-1:0]  cause,
    input logic [GL_WB_EXC_ORIGIN_W-1:0] origin
  );
    logic [GL_NWAY_WB_DATA_W-1:0] w;
    w = '0;
    w[GL_WB_EXC_VALID_OFF] = 1'b1;
    w[GL_WB_EXC_CAUSE_OFF +: GL_WB_EXC_CAUSE_W] = cause;
    w[GL_WB_EXC_ORIGIN_OFF +: GL_WB_EXC_ORIGIN_W] = origin;
    return w;
  endfunction

endpackage

// File: rtl/graduation_list_nway_commit_select.sv
// Prefix-AND retire selection: lane k retires only if every older lane retires.
module graduation_list_nway_commit_select #(
  parameter int COMMIT_W = 2,
  parameter int CNT_W    = $clog2(COMMIT_W + 1)
) (
  input  logic [COMMIT_W-1:0] ready,
  input  logic [COMMIT_W-1:0] cand,
  output logic [COMMIT_W-1:0] mask,
  output logic [CNT_W-1:0]    cnt
);

  logic chain;

  always_comb begin
    mask  = '0;
    cnt   = '0;
    chain = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      chain   = chain & ready[k] & cand[k];
      mask[k] = chain;
      cnt     = cnt + CNT_W'(chain);
    end
  end

endmodule

// File: rtl/graduation_list_nway.sv
// N-way in-order graduation list with partial flush and per-lane commit handshake.
// Optional stall counters are built when GL_STALL_COUNTERS_EN is defined.
module graduation_list_nway
  import graduation_list_nway_pkg::*;
#(
  parameter int GL_ENTRIES = GL_NWAY_ENTRIES,
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int WB_PORTS   = 4,
  parameter int PAYLOAD_W  = 128,
  parameter int WB_DATA_W  = GL_NWAY_WB_DATA_W,
  parameter int IDX_W      = $clog2(GL_ENTRIES)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [DISPATCH_W-1:0]           dispatch_valid_i,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0] dispatch_payload_i,
  output logic                            dispatch_ready_o,
  output logic [IDX_W-1:0]                assigned_idx_o,
  input  logic [WB_PORTS-1:0]             wb_valid_i,
  input  logic [WB_PORTS*IDX_W-1:0]       wb_idx_i,
  input  logic [WB_PORTS*WB_DATA_W-1:0]   wb_data_i,
  input  logic [COMMIT_W-1:0]             commit_ready_i,
  output logic [COMMIT_W-1:0]             commit_valid_o,
  output logic [COMMIT_W*PAYLOAD_W-1:0]   commit_payload_o,
  output logic [COMMIT_W*WB_DATA_W-1:0]   commit_wb_data_o,
  output logic [IDX_W-1:0]                commit_idx_o,
  input  logic                            flush_i,
  input  logic [IDX_W-1:0]                flush_idx_i,
  input  logic                            flush_all_i,
  output logic [IDX_W:0]                  count_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [31:0]                     stall_full_cnt_o,
  output logic [31:0]                     stall_head_cnt_o
);

  localparam int CNT_W  = $clog2(COMMIT_W + 1);
  localparam int DCNT_W = $clog2(DISPATCH_W + 1);

  typedef logic [IDX_W:0] ptr_t;

  ptr_t                  head_q, tail_q;
  logic [IDX_W:0]        count;
  logic [GL_ENTRIES-1:0] valid_q, done_q;
  logic [PAYLOAD_W-1:0]  payload_q [GL_ENTRIES];
  logic [WB_DATA_W-1:0]  wb_q      [GL_ENTRIES];

  logic [IDX_W-1:0] head_idx, tail_idx, flush_off;
  logic             flush_ok, dispatch_fire;
  logic [IDX_W:0]   commit_limit;
  logic [DCNT_W-1:0] disp_cnt;

  logic [IDX_W-1:0]    lane_idx [COMMIT_W];
  logic [COMMIT_W-1:0] cand, retire_mask;
  logic [CNT_W-1:0]    retire_cnt;

  logic [COMMIT_W-1:0]                commit_valid_q;
  logic [IDX_W-1:0]                   commit_idx_q;
  logic [COMMIT_W-1:0][PAYLOAD_W-1:0] commit_payload_q;
  logic [COMMIT_W-1:0][WB_DATA_W-1:0] commit_wb_q;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign count    = tail_q - head_q;

  assign count_o          = count;
  assign full_o           = (count == (IDX_W+1)'(GL_ENTRIES));
  assign empty_o          = (count == '0);
  assign dispatch_ready_o = (((IDX_W+1)'(GL_ENTRIES) - count) >= (IDX_W+1)'(DISPATCH_W));
  assign assigned_idx_o   = tail_idx;

  // A partial flush only counts when the surviving index lies inside the occupied window.
  assign flush_off     = flush_idx_i - head_idx;
  assign flush_ok      = flush_i && !flush_all_i && ({1'b0, flush_off} < count);
  assign commit_limit  = flush_ok ? ({1'b0, flush_off} + (IDX_W+1)'(1)) : count;
  assign dispatch_fire = dispatch_ready_o && !flush_i && !flush_all_i;

  always_comb begin
    disp_cnt = '0;
    for (int d = 0; d < DISPATCH_W; d++) begin
      disp_cnt = disp_cnt + DCNT_W'(dispatch_valid_i[d]);
    end
  end

  always_comb begin
    cand = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      lane_idx[k] = head_idx + IDX_W'(k);
      cand[k] = valid_q[lane_idx[k]] && done_q[lane_idx[k]] &&
                ((IDX_W+1)'(k) < commit_limit) && !flush_all_i;
    end
  end

  // Handshake: lane k transfers on an edge where commit_ready_i[k] is high and the
  // entry is eligible; the retired entry is then shown, registered, on commit_*
  // for exactly one cycle with commit_valid_o[k] high.
  graduation_list_nway_commit_select #(
    .COMMIT_W (COMMIT_W),
    .CNT_W    (CNT_W)
  ) u_commit_select (
    .ready (commit_ready_i),
    .cand  (cand),
    .mask  (retire_mask),
    .cnt   (retire_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q           <= '0;
      tail_q           <= '0;
      valid_q          <= '0;
      done_q           <= '0;
      commit_valid_q   <= '0;
      commit_idx_q     <= '0;
      commit_payload_q <= '0;
      commit_wb_q      <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid_i[p] && valid_q[wb_idx_i[p*IDX_W +: IDX_W]]) begin
          done_q[wb_idx_i[p*IDX_W +: IDX_W]] <= 1'b1;
        end
      end
      if (flush_all_i) begin
        tail_q           <= head_q;
        valid_q          <= '0;
        done_q           <= '0;
        commit_valid_q   <= '0;
        commit_idx_q     <= '0;
        commit_payload_q <= '0;
        commit_wb_q      <= '0;
      end else begin
        for (int k = 0; k < COMMIT_W; k++) begin
          if (retire_mask[k]) begin
            valid_q[lane_idx[k]] <= 1'b0;
            done_q[lane_idx[k]]  <= 1'b0;
          end
        end
        head_q         <= head_q + ptr_t'(retire_cnt);
        commit_valid_q <= retire_mask;
        if (|retire_mask) begin
          commit_idx_q <= head_idx;
          for (int k = 0; k < COMMIT_W; k++) begin
            commit_payload_q[k] <= payload_q[lane_idx[k]];
            commit_wb_q[k]      <= wb_q[lane_idx[k]];
          end
        end
        if (flush_ok) begin
          // Adding the offset to the full head pointer recomputes the wrap bit.
          tail_q <= head_q + ptr_t'(flush_off) + ptr_t'(1);
          for (int e = 0; e < GL_ENTRIES; e++) begin
            if ((IDX_W'(e) - head_idx) > flush_off) begin
              valid_q[e] <= 1'b0;
              done_q[e]  <= 1'b0;
            end
          end
        end else if (dispatch_fire) begin
          for (int d = 0; d < DISPATCH_W; d++) begin
            if (dispatch_valid_i[d]) begin
              valid_q[tail_idx + IDX_W'(d)] <= 1'b1;
              done_q[tail_idx + IDX_W'(d)]  <= 1'b0;
            end
          end
          tail_q <= tail_q + ptr_t'(disp_cnt);
        end
      end
    end
  end

  // Payload and writeback storage carry no reset; valid_q qualifies every read.
  always_ff @(posedge clk_i) begin
    if (dispatch_fire) begin
      for (int d = 0; d < DISPATCH_W; d++) begin
        if (dispatch_valid_i[d]) begin
          payload_q[tail_idx + IDX_W'(d)] <= dispatch_payload_i[d*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid_i[p] && valid_q[wb_idx_i[p*IDX_W +: IDX_W]]) begin
        wb_q[wb_idx_i[p*IDX_W +: IDX_W]] <= wb_data_i[p*WB_DATA_W +: WB_DATA_W];
      end
    end
  end

  assign commit_valid_o   = commit_valid_q;
  assign commit_idx_o     = commit_idx_q;
  assign commit_payload_o = commit_payload_q;
  assign commit_wb_data_o = commit_wb_q;

`ifdef GL_STALL_COUNTERS_EN
  logic [31:0] stall_full_q, stall_head_q;
  logic        head_stall;

  assign head_stall = !empty_o && !(valid_q[head_idx] && done_q[head_idx]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_full_q <= '0;
      stall_head_q <= '0;
    end else begin
      if (full_o && (|dispatch_valid_i) && (stall_full_q != '1)) begin
        stall_full_q <= stall_full_q + 32'd1;
      end
      if (head_stall && (stall_head_q != '1)) begin
        stall_head_q <= stall_head_q + 32'd1;
      end
    end
  end

  assign stall_full_cnt_o = stall_full_q;
  assign stall_head_cnt_o = stall_head_q;
`else
  assign stall_full_cnt_o = '0;
  assign stall_head_cnt_o = '0;
`endif

endmodule

// File: tb/tb_graduation_list_nway.sv
// Directed bench for graduation_list_nway with a commit scoreboard.
module tb_graduation_list_nway;
  import graduation_list_nway_pkg::*;

  localparam int IDX_W = 5;
  localparam int PW    = 128;
  localparam int WDW   = 136;
  localparam int SB_W  = 2 + IDX_W + 64 + 34;

  logic             clk, rst;
  logic [1:0]       dispatch_valid;
  logic [2*PW-1:0]  dispatch_payload;
  logic             dispatch_ready;
  logic [IDX_W-1:0] assigned_idx;
  logic [3:0]       wb_valid;
  logic [4*IDX_W-1:0] wb_idx;
  logic [4*WDW-1:0] wb_data;
  logic [1:0]       commit_ready;
  logic [1:0]       commit_valid;
  logic [2*PW-1:0]  commit_payload;
  logic [2*WDW-1:0] commit_wb_data;
  logic [IDX_W-1:0] commit_idx;
  logic             flush, flush_all;
  logic [IDX_W-1:0] flush_idx;
  logic [IDX_W:0]   count;
  logic             full, empty;
  logic [31:0]      stall_full_cnt, stall_head_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [SB_W-1:0] exp_q[$];

  graduation_list_nway dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .dispatch_valid_i   (dispatch_valid),
    .dispatch_payload_i (dispatch_payload),
    .dispatch_ready_o   (dispatch_ready),
    .assigned_idx_o     (assigned_idx),
    .wb_valid_i         (wb_valid),
    .wb_idx_i           (wb_idx),
    .wb_data_i          (wb_data),
    .commit_ready_i     (commit_ready),
    .commit_valid_o     (commit_valid),
    .commit_payload_o   (commit_payload),
    .commit_wb_data_o   (commit_wb_data),
    .commit_idx_o       (commit_idx),
    .flush_i            (flush),
    .flush_idx_i        (flush_idx),
    .flush_all_i        (flush_all),
    .count_o            (count),
    .full_o             (full),
    .empty_o            (empty),
    .stall_full_cnt_o   (stall_full_cnt),
    .stall_head_cnt_o   (stall_head_cnt)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [SB_W-1:0] sb_word(input logic [1:0] m, input int idx,
                                               input int pc0, input int pc1,
                                               input int org0, input int org1);
    logic [31:0] p0, p1;
    logic [16:0] w0, w1;
    p0 = m[0] ? 32'(pc0) : 32'd0;
    p1 = m[1] ? 32'(pc1) : 32'd0;
    w0 = m[0] ? {8'(org0), 8'd1, 1'b1} : 17'd0;
    w1 = m[1] ? {8'(org1), 8'd1, 1'b1} : 17'd0;
    return {m, IDX_W'(idx), p0, p1, w0, w1};
  endfunction

  // Monitor: pops one expectation per presented commit
  always @(negedge clk) begin
    logic [SB_W-1:0] act, exp_w;
    if (!rst && commit_valid != 2'b00) begin
      act = {commit_valid, commit_idx,
             commit_valid[0] ? commit_payload[31:0]    : 32'd0,
             commit_valid[1] ? commit_payload[159:128] : 32'd0,
             commit_valid[0] ? commit_wb_data[16:0]    : 17'd0,
             commit_valid[1] ? commit_wb_data[152:136] : 17'd0};
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL unexpected_commit: got %h expected nothing", act);
      end else begin
        exp_w = exp_q.pop_front();
        if (act !== exp_w) begin
          err_cnt++;
          $display("FAIL commit_sb: got %h expected %h", act, exp_w);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vec_cnt++;
    if (act !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic disp(input logic [1:0] v, input int pc0, input int pc1);
    dispatch_valid   = v;
    dispatch_payload = {96'd0, 32'(pc1), 96'd0, 32'(pc0)};
    step();
    dispatch_valid = 2'b00;
  endtask

  task automatic wb_cycle(input logic [3:0] v, input logic [3:0][4:0] idx,
                          input logic [3:0][7:0] org);
    wb_valid = v;
    for (int p = 0; p < 4; p++) begin
      wb_idx[p*IDX_W +: IDX_W] = idx[p];
      wb_data[p*WDW +: WDW]    = gl_nway_exc_word(8'd1, 64'(org[p]));
    end
    step();
    wb_valid = 4'b0000;
  endtask

  task automatic wb_range(input int start, input int n);
    logic [3:0]      v;
    logic [3:0][4:0] idx;
    logic [3:0][7:0] org;
    v = '0;
    idx = '0;
    org = '0;
    for (int p = 0; p < n; p++) begin
      v[p]   = 1'b1;
      idx[p] = 5'(start + p);
      org[p] = 8'(start + p);
    end
    wb_cycle(v, idx, org);
  endtask

  task automatic wait_empty(input int max_cycles);
    for (int i = 0; i < max_cycles && !empty; i++) step();
    check("wait_empty", 64'(empty), 64'd1);
    step();
  endtask

  // Stimulus
  initial begin
    logic [3:0][4:0] ia;
    logic [3:0][7:0] oa;
    rst = 1'b1;
    dispatch_valid = '0; dispatch_payload = '0;
    wb_valid = '0; wb_idx = '0; wb_data = '0;
    commit_ready = 2'b11;
    flush = 1'b0; flush_idx = '0; flush_all = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    check("reset_count", 64'(count), 64'd0);
    check("reset_empty", 64'(empty), 64'd1);
    check("reset_full", 64'(full), 64'd0);
    check("reset_ready", 64'(dispatch_ready), 64'd1);
    check("reset_commit_valid", 64'(commit_valid), 64'd0);
    check("reset_commit_idx", 64'(commit_idx), 64'd0);
    check("reset_commit_payload", commit_payload[63:0], 64'd0);
    check("reset_assigned", 64'(assigned_idx), 64'd0);

    // Fill all 32 entries, pc == index
    for (int c = 0; c < 16; c++) begin
      check("assigned_idx_fill", 64'(assigned_idx), 64'(2*c));
      disp(2'b11, 2*c, 2*c+1);
    end
    check("full_after_fill", 64'(full), 64'd1);
    check("ready_when_full", 64'(dispatch_ready), 64'd0);
    check("count_full", 64'(count), 64'd32);
    dispatch_valid   = 2'b11;
    dispatch_payload = {96'd0, 32'd99, 96'd0, 32'd98};
    repeat (5) step();
    dispatch_valid = 2'b00;
    check("count_after_drop", 64'(count), 64'd32);
`ifdef GL_STALL_COUNTERS_EN
    check("stall_full_cnt", 64'(stall_full_cnt), 64'd5);
`else
    check("stall_full_cnt", 64'(stall_full_cnt), 64'd0);
`endif

    // Entry 1 done but head not: nothing retires
    wb_range(1, 1);
    step();
    check("count_head_not_done", 64'(count), 64'd32);
    // Both head entries done, but lane 0 not ready
    commit_ready = 2'b10;
    wb_range(0, 1);
    step();
    step();
    check("count_prefix_rule", 64'(count), 64'd32);
    for (int j = 0; j < 16; j++) exp_q.push_back(sb_word(2'b11, 2*j, 2*j, 2*j+1, 2*j, 2*j+1));
    commit_ready = 2'b11;
    for (int s = 0; s < 8; s++) wb_range(2 + 4*s, (s == 7) ? 2 : 4);
    wait_empty(64);
    check("count_drained", 64'(count), 64'd0);
    check("sb_drain_1", 64'(exp_q.size()), 64'd0);

    // Advance head to 4
    disp(2'b11, 100, 101);
    disp(2'b11, 102, 103);
    exp_q.push_back(sb_word(2'b11, 0, 100, 101, 0, 1));
    exp_q.push_back(sb_word(2'b11, 2, 102, 103, 2, 3));
    wb_range(0, 4);
    wait_empty(16);

    // 10 entries at 4..13, then flush keeping 4..7 with a dropped dispatch
    for (int c = 0; c < 5; c++) begin
      check("assigned_idx_flush", 64'(assigned_idx), 64'(4 + 2*c));
      disp(2'b11, 204 + 2*c, 205 + 2*c);
    end
    check("count_ten", 64'(count), 64'd10);
    flush = 1'b1;
    flush_idx = 5'd7;
    dispatch_valid = 2'b11;
    step();
    flush = 1'b0;
    dispatch_valid = 2'b00;
    check("count_after_flush", 64'(count), 64'd4);
    check("assigned_after_flush", 64'(assigned_idx), 64'd8);
    flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    check("empty_after_flush_all", 64'(empty), 64'd1);
    check("count_after_flush_all", 64'(count), 64'd0);
    check("assigned_after_flush_all", 64'(assigned_idx), 64'd4);
    check("commit_valid_after_flush_all", 64'(commit_valid), 64'd0);

    // Move head to 30
    for (int c = 0; c < 13; c++) disp(2'b11, 304 + 2*c, 305 + 2*c);
    for (int j = 0; j < 13; j++)
      exp_q.push_back(sb_word(2'b11, 4 + 2*j, 304 + 2*j, 305 + 2*j, 4 + 2*j, 5 + 2*j));
    for (int s = 0; s < 7; s++) wb_range(4 + 4*s, (s == 6) ? 2 : 4);
    wait_empty(64);
    check("sb_drain_2", 64'(exp_q.size()), 64'd0);

    // Wrap-around: indices 30,31,0,1
    commit_ready = 2'b00;
    check("assigned_wrap_30", 64'(assigned_idx), 64'd30);
    disp(2'b11, 530, 531);
    check("assigned_wrap_0", 64'(assigned_idx), 64'd0);
    disp(2'b11, 532, 533);
    check("count_wrap", 64'(count), 64'd4);
    flush = 1'b1;
    flush_idx = 5'd5;
    step();
    flush = 1'b0;
    check("count_flush_out_of_range", 64'(count), 64'd4);
    // Ports 0 and 3 both target 30; port 3 must win
    ia = '0; oa = '0;
    ia[0] = 5'd30; oa[0] = 8'd99;
    ia[1] = 5'd31; oa[1] = 8'd31;
    ia[2] = 5'd0;  oa[2] = 8'd0;
    ia[3] = 5'd30; oa[3] = 8'd30;
    wb_cycle(4'b1111, ia, oa);
    ia = '0; oa = '0;
    ia[0] = 5'd1; oa[0] = 8'd1;
    ia[1] = 5'd5; oa[1] = 8'd77;
    wb_cycle(4'b0011, ia, oa);
    exp_q.push_back(sb_word(2'b11, 30, 530, 531, 30, 31));
    exp_q.push_back(sb_word(2'b11, 0, 532, 533, 0, 1));
    commit_ready = 2'b11;
    wait_empty(16);

    // Writeback to an empty slot must not pre-complete a later dispatch there
    wb_range(2, 1);
    check("assigned_before_late", 64'(assigned_idx), 64'd2);
    disp(2'b11, 600, 601);
    step();
    step();
    check("count_invalid_wb_ignored", 64'(count), 64'd2);
    exp_q.push_back(sb_word(2'b11, 2, 600, 601, 2, 3));
    wb_range(2, 2);
    wait_empty(16);
    check("sb_drain_final", 64'(exp_q.size()), 64'd0);
`ifndef GL_STALL_COUNTERS_EN
    check("stall_head_cnt", 64'(stall_head_cnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
